// File: rtl/regfile_pkg.sv
// Shared register-file sizing and writeback priority state.
package regfile_pkg;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 16;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } pri_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for decode-stage RAW/WAW hazard detection.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  hazard
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;

  always_comb begin
    hazard = !rst && issue_valid &&
             (r_busy[issue_rs1] || r_busy[issue_rs2] || (issue_we && r_busy[issue_rd]));
  end

  // Clear is applied before set so a same-cycle reissue of the retiring register stays busy.
  always_comb begin
    w_busy_next = r_busy;
    if (wb_we) w_busy_next[wb_addr] = 1'b0;
    if (issue_valid && issue_we && !hazard) w_busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source (ALU/LSU) round-robin writeback arbiter with registered write port.
// Optional hazard scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [REG_DATA_W-1:0] alu_wd,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [REG_DATA_W-1:0] lsu_wd,
  output logic                  lsu_ready,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [REG_DATA_W-1:0] wb_data,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  output logic                  hazard
);
  pri_e                  r_pri;
  pri_e                  w_pri_next;
  logic                  w_grant_alu;
  logic                  w_grant_lsu;
  logic                  r_wb_we;
  logic [REG_ADDR_W-1:0] r_wb_addr;
  logic [REG_DATA_W-1:0] r_wb_data;

  always_comb begin
    w_pri_next  = r_pri;
    w_grant_alu = 1'b0;
    w_grant_lsu = 1'b0;
    if (!rst) begin
      w_grant_alu = alu_valid && (!lsu_valid || r_pri == PRI_ALU);
      w_grant_lsu = lsu_valid && (!alu_valid || r_pri == PRI_LSU);
      if (alu_valid && lsu_valid) w_pri_next = (r_pri == PRI_ALU) ? PRI_LSU : PRI_ALU;
    end
    alu_ready = w_grant_alu;
    lsu_ready = w_grant_lsu;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pri     <= PRI_ALU;
      r_wb_we   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_pri   <= w_pri_next;
      r_wb_we <= w_grant_alu || w_grant_lsu;
      if (w_grant_alu) begin
        r_wb_addr <= alu_rd;
        r_wb_data <= alu_wd;
      end else if (w_grant_lsu) begin
        r_wb_addr <= lsu_rd;
        r_wb_data <= lsu_wd;
      end
    end
  end

  assign wb_we   = r_wb_we;
  assign wb_addr = r_wb_addr;
  assign wb_data = r_wb_data;

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .wb_we       (r_wb_we),
    .wb_addr     (r_wb_addr),
    .hazard      (hazard)
  );
`else
  logic w_unused_issue;
  assign w_unused_issue = ^{issue_valid, issue_we, issue_rd, issue_rs1, issue_rs2};
  assign hazard         = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; hazard expectations follow REGFILE_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [3:0]  alu_rd, lsu_rd;
  logic [31:0] alu_wd, lsu_wd;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        issue_valid, issue_we, hazard;
  logic [3:0]  issue_rd, issue_rs1, issue_rs2;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned edge_n = 0;

  // Reference state: who wins a tie next, which registers await writeback, and the write due next edge.
  bit          m_alu_first;
  logic [15:0] m_busy;
  bit          m_pend_v;
  logic [3:0]  m_pend_a;

  // Persistent requester state for randomized traffic (held until granted).
  bit          a_v, l_v;
  logic [3:0]  a_r, l_r;
  logic [31:0] a_w, l_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check combinational outputs, queue the expected write, advance model.
  task automatic step(input bit r,
                      input bit av, input logic [3:0] ar, input logic [31:0] aw,
                      input bit lv, input logic [3:0] lr, input logic [31:0] lw,
                      input bit iv, input bit iw, input logic [3:0] ird,
                      input logic [3:0] irs1, input logic [3:0] irs2,
                      output bit ga, output bit gl);
    bit  ex_h;
    wr_t w;
    rst = r;
    alu_valid = av; alu_rd = ar; alu_wd = aw;
    lsu_valid = lv; lsu_rd = lr; lsu_wd = lw;
    issue_valid = iv; issue_we = iw; issue_rd = ird; issue_rs1 = irs1; issue_rs2 = irs2;
    #1;
    ga = !r && av && (!lv || m_alu_first);
    gl = !r && lv && (!av || !m_alu_first);
    ex_h = SB_EN && !r && iv && (m_busy[irs1] || m_busy[irs2] || (iw && m_busy[ird]));
    chk("alu_ready", 32'(alu_ready), 32'(ga));
    chk("lsu_ready", 32'(lsu_ready), 32'(gl));
    chk("hazard", 32'(hazard), 32'(ex_h));
    if (ga || gl) begin
      w.cyc  = edge_n + 1;
      w.addr = ga ? ar : lr;
      w.data = ga ? aw : lw;
      exp_q.push_back(w);
    end
    if (r) begin
      m_alu_first = 1'b1;
      m_busy      = '0;
      m_pend_v    = 1'b0;
    end else begin
      if (av && lv) m_alu_first = !m_alu_first;
      if (m_pend_v) m_busy[m_pend_a] = 1'b0;
      if (iv && iw && !ex_h) m_busy[ird] = 1'b1;
      m_pend_v = ga || gl;
      m_pend_a = ga ? ar : lr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int n, input int unsigned pct);
    bit ga, gl;
    for (int i = 0; i < n; i++) begin
      if (!a_v && $urandom_range(99, 0) < pct) begin
        a_v = 1'b1; a_r = 4'($urandom_range(15, 0)); a_w = $urandom;
      end
      if (!l_v && $urandom_range(99, 0) < pct) begin
        l_v = 1'b1; l_r = 4'($urandom_range(15, 0)); l_w = $urandom;
      end
      step(1'b0, a_v, a_r, a_w, l_v, l_r, l_w,
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
           ga, gl);
      if (ga) a_v = 1'b0;
      if (gl) l_v = 1'b0;
    end
  endtask

  // Monitor: every edge must produce exactly the write the model queued for it, or hold the port.
  initial begin : monitor
    bit          rs, ex_we;
    wr_t         w;
    logic [3:0]  last_a;
    logic [31:0] last_d;
    last_a = '0;
    last_d = '0;
    forever begin
      @(posedge clk);
      rs = rst;
      edge_n++;
      @(negedge clk);
      if (rs) begin
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        last_a = '0;
        last_d = '0;
      end else begin
        ex_we = (exp_q.size() > 0) && (exp_q[0].cyc == edge_n);
        chk("wb_we", 32'(wb_we), 32'(ex_we));
        if (ex_we) begin
          w = exp_q.pop_front();
          chk("wb_addr", 32'(wb_addr), 32'(w.addr));
          chk("wb_data", wb_data, w.data);
          last_a = w.addr;
          last_d = w.data;
        end else begin
          chk("hold_wb_addr", 32'(wb_addr), 32'(last_a));
          chk("hold_wb_data", wb_data, last_d);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin : stim
    bit ga, gl;
    m_alu_first = 1'b1; m_busy = '0; m_pend_v = 1'b0; m_pend_a = '0;
    a_v = 1'b0; l_v = 1'b0; a_r = '0; l_r = '0; a_w = '0; l_w = '0;

    // Reset with live requests: no grants, no hazard.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 4'd4, 32'h1111_1111, 1'b1, 4'd6, 32'h2222_2222,
           1'b1, 1'b1, 4'd1, 4'd1, 4'd1, ga, gl);

    // Single ALU write.
    step(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ga, gl);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ga, gl);

    // Contention at reset priority: ALU first, LSU held and granted next.
    step(1'b0, 1'b1, 4'd1, 32'hA1A1_A1A1, 1'b1, 4'd2, 32'hB2B2_B2B2, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ga, gl);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'hB2B2_B2B2, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ga, gl);

    // Six cycles of continuous contention.
    run_random(6, 100);
    while (a_v || l_v) run_random(1, 0);

    // RAW hazard held until the write to r5 retires.
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 4'd5, 4'd0, 4'd0, ga, gl);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 4'd5, 4'd0, ga, gl);
    step(1'b0, 1'b1, 4'd5, 32'h5555_5555, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 4'd5, 4'd0, ga, gl);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 4'd5, 4'd0, ga, gl);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 4'd5, 4'd0, ga, gl);

    // Same-edge clear and set of r7 (R15 write rides along through the LSU).
    step(1'b0, 1'b1, 4'd7, 32'h7777_7777, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ga, gl);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'hF0F0_0F0F, 1'b1, 1'b1, 4'd7, 4'd0, 4'd0, ga, gl);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd7, ga, gl);

    // Reset in the middle of contention with a write in flight.
    step(1'b0, 1'b1, 4'd9, 32'h9999_9999, 1'b1, 4'd10, 32'hAAAA_0000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ga, gl);
    step(1'b0, 1'b1, 4'd11, 32'hBBBB_0000, 1'b1, 4'd10, 32'hAAAA_0000, 1'b1, 1'b1, 4'd12, 4'd0, 4'd0, ga, gl);
    step(1'b1, 1'b1, 4'd11, 32'hBBBB_0000, 1'b1, 4'd10, 32'hAAAA_0000, 1'b1, 1'b1, 4'd12, 4'd0, 4'd0, ga, gl);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 4'd7, 4'd12, ga, gl);
    step(1'b0, 1'b1, 4'd13, 32'hCCCC_0000, 1'b1, 4'd14, 32'hDDDD_0000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ga, gl);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd14, 32'hDDDD_0000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ga, gl);

    // Randomized traffic, then drain.
    run_random(400, 60);
    for (int i = 0; i < 10 && (a_v || l_v); i++) run_random(1, 0);
    chk("drain_requests", 32'({a_v, l_v}), 32'd0);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ga, gl);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ga, gl);
    chk("expect_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports alu_valid in 1, alu_rd in 4, alu_wd in 32  ALU writeback request, dest, data.
REQ-004 SHALL have port alu_ready  out  1  ALU request accepted this cycle.
REQ-005 SHALL have ports lsu_valid in 1, lsu_rd in 4, lsu_wd in 32  load-unit writeback request, dest, data.
REQ-006 SHALL have port lsu_ready  out  1  LSU request accepted this cycle.
REQ-007 SHALL have ports wb_we out 1, wb_addr out 4, wb_data out 32  registered write port driving register-file WE/A3/WD3.
REQ-008 SHALL have ports issue_valid in 1, issue_we in 1, issue_rd in 4, issue_rs1 in 4, issue_rs2 in 4  decode-stage issue request.
REQ-009 SHALL have port hazard  out  1  issue must stall (combinational).

Function
REQ-010 SHALL grant at most one writeback request per cycle; ready is combinational from valid and priority state.
REQ-011 SHALL hold priority state PRI_ALU or PRI_LSU; with one valid, that source wins; with both valid, the prioritised source wins.
REQ-012 SHALL move priority to the other source after each grant when both were valid; single-requester grants leave priority unchanged.
REQ-013 SHALL register the granted rd/wd onto wb_addr/wb_data with wb_we=1 on the next edge (1-cycle latency); wb_we=0 on any cycle without a grant.
REQ-014 SHALL keep wb_addr/wb_data at their last values when wb_we=0.
REQ-015 SHALL require requesters to hold valid, rd and wd stable until ready; a losing request is not lost, only delayed.
REQ-016 SHALL pass rd=15 writes through unchanged; R15 arbitration against PC update is outside this block.
REQ-017 SHALL provide full throughput: back-to-back grants on consecutive cycles, one write per cycle.

Reset
REQ-018 SHALL on rst set wb_we=0, wb_addr=0, wb_data=0, priority=PRI_ALU, all busy bits=0.
REQ-019 SHALL drop any in-flight grant on rst mid-operation; ready outputs are 0 while rst=1.
REQ-020 SHALL produce hazard=0 while rst=1.

Configuration
REQ-021 SHALL compile the scoreboard only when REGFILE_SCOREBOARD_EN is defined.
REQ-022 With REGFILE_SCOREBOARD_EN: 16-bit busy vector; hazard = issue_valid & (busy[rs1] | busy[rs2] | (issue_we & busy[rd])).
REQ-023 With REGFILE_SCOREBOARD_EN: busy[issue_rd] set on edge when issue_valid & issue_we & !hazard; busy[wb_addr] cleared on edge when wb_we=1.
REQ-024 With REGFILE_SCOREBOARD_EN: simultaneous set and clear of the same bit SHALL leave it set.
REQ-025 Without REGFILE_SCOREBOARD_EN: hazard tied 0, no busy storage, issue_* inputs unused.

Structure
REQ-026 SHALL place REG_ADDR_W=4, REG_DATA_W=32, NUM_REGS=16 and the priority-state enum in a shared package regfile_pkg.
REQ-027 SHALL implement the scoreboard as sub-module regfile_scoreboard, instantiated under the macro.
REQ-028 SHALL target 120-400 lines total RTL.

Verification
REQ-029 Only alu_valid=1 rd=3 wd=0xDEADBEEF -> alu_ready=1 same cycle; next cycle wb_we=1 wb_addr=3 wb_data=0xDEADBEEF.
REQ-030 Both valid at reset priority, ALU rd=1, LSU rd=2, held -> cycle0 ALU granted, cycle1 LSU granted; wb_addr 1 then 2 on consecutive cycles.
REQ-031 Both valid continuously for 6 cycles -> grants alternate ALU,LSU,ALU,LSU,ALU,LSU; wb_we=1 every cycle.
REQ-032 Scoreboard: issue rd=5 accepted; next issue rs1=5 -> hazard=1 until wb_we=1 wb_addr=5 edge, then hazard=0.
REQ-033 Scoreboard: same cycle wb clears reg 7 and issue sets reg 7 -> busy[7]=1 afterward; issue rs2=7 sees hazard=1.
REQ-034 rst asserted while both valid and wb_we=1 -> next cycle wb_we=0, wb_addr=0, busy=0, priority PRI_ALU.
